// File: rtl/spi_frame_master_pkg.sv
// Shared types and defaults for the SPI register-frame master.
// The FSM state encoding and default field widths are common to the master, its slave and benches.
package spi_frame_master_pkg;

    localparam int DEF_ADDR_W       = 8;
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_DUMMY_CYCLES = 6;
    localparam int DEF_CLK_DIV      = 2;
    localparam int DEF_CS_GAP       = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_TRAIL,
        ST_GAP
    } frame_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_frame_master_sck_gen.sv
// SCK half-period divider: toggles SCK every CLK_DIV cycles while enabled and
// flags the cycle on which SCK is about to rise or fall.
module spi_sck_gen
    import spi_frame_master_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = cnt_w(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise = tick && !sck;
    assign fall = tick && sck;

    // Disabling parks SCK low with the divider cleared, so every frame
    // starts with a full half-period of SCK low.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || !en) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 initiator for the board register frame: address, dummy clocks, data,
// MSB first, with MISO captured during address and data phases.
module spi_frame_master
    import spi_frame_master_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DUMMY_CYCLES = DEF_DUMMY_CYCLES,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int CS_GAP       = DEF_CS_GAP
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs_n
);

    localparam int BIT_W  = cnt_w(max3(ADDR_W, DATA_W, DUMMY_CYCLES));
    localparam int WAIT_W = cnt_w((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP);

    frame_state_t      state, state_nx;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] tx_addr, rx_addr;
    logic [DATA_W-1:0] tx_data, rx_data;
    logic              sck_en, sck_rise, sck_fall;
    logic              accept;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign sck_en    = (state == ST_ADDR) || (state == ST_DUMMY) || (state == ST_DATA);
    assign spi_cs_n  = !(sck_en || (state == ST_TRAIL));
    assign spi_mosi  = (state == ST_ADDR) ? tx_addr[ADDR_W-1] :
                       (state == ST_DATA) ? tx_data[DATA_W-1] : 1'b0;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (sck_en),
        .sck       (spi_clk),
        .rise      (sck_rise),
        .fall      (sck_fall)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (cmd_valid) state_nx = ST_ADDR;
            ST_ADDR:  if (sck_fall && bit_cnt == BIT_W'(ADDR_W - 1))
                          state_nx = (DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
            ST_DUMMY: if (sck_fall && bit_cnt == BIT_W'(DUMMY_CYCLES - 1)) state_nx = ST_DATA;
            ST_DATA:  if (sck_fall && bit_cnt == BIT_W'(DATA_W - 1)) state_nx = ST_TRAIL;
            ST_TRAIL: if (wait_cnt == WAIT_W'(CLK_DIV - 1)) state_nx = ST_GAP;
            ST_GAP:   if (wait_cnt == WAIT_W'(CS_GAP - 1)) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            tx_addr   <= '0;
            tx_data   <= '0;
            rx_addr   <= '0;
            rx_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;

            // Both counters restart on every phase change.
            if (state_nx != state) begin
                bit_cnt  <= '0;
                wait_cnt <= '0;
            end else if (sck_fall) begin
                bit_cnt  <= bit_cnt + BIT_W'(1);
            end else if (state == ST_TRAIL || state == ST_GAP) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (accept) begin
                tx_addr <= cmd_addr;
                tx_data <= cmd_data;
            end

            if (sck_fall && state == ST_ADDR) begin
                tx_addr <= {tx_addr[ADDR_W-2:0], 1'b0};
                rx_addr <= {rx_addr[ADDR_W-2:0], spi_miso};
            end
            if (sck_fall && state == ST_DATA) begin
                tx_data <= {tx_data[DATA_W-2:0], 1'b0};
                rx_data <= {rx_data[DATA_W-2:0], spi_miso};
            end

            if (state == ST_TRAIL && state_nx == ST_GAP) begin
                rsp_valid <= 1'b1;
                rsp_addr  <= rx_addr;
                rsp_data  <= rx_data;
            end
        end
    end

endmodule
